// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-control block: FSM state encoding,
// cycle-counter width, default timing parameters and a counter-width helper.
package cpu_clk_pkg;

  localparam int CYC_W          = 16;
  localparam int DEF_DIV_HALF   = 50000;
  localparam int DEF_DEB_CYCLES = 20000;
  localparam int DEF_PULSE_LEN  = 1000;

  typedef enum logic [2:0] {
    RUN_LO    = 3'd0,
    RUN_HI    = 3'd1,
    STEP_IDLE = 3'd2,
    STEP_HI   = 3'd3,
    BREAK     = 3'd4
  } clk_state_t;

  // Width of a counter that runs 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-switch conditioner: 2-FF synchroniser, stable-level debouncer and a
// one-cycle press strobe on each accepted 0->1 transition.
module key_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int DEB_W = cnt_width(DEB_CYCLES);

  logic [1:0]       sync;
  logic [DEB_W-1:0] deb_cnt;

  // NOTE: state updates use <= so every flop samples pre-edge values; = here would chain the synchroniser into one stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      deb_cnt <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      press <= 1'b0;
      if (sync[1] == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        deb_cnt <= '0;
        level   <= sync[1];
        press   <= sync[1];
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Registered, glitch-free CPU clock generator with run / single-step modes and
// a rising-edge cycle counter. Define CPU_CLK_BREAK_EN to add the PR breakpoint.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_HALF   = DEF_DIV_HALF,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_LEN  = DEF_PULSE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_view,
  input  logic             step_key,
  input  logic [7:0]       pr,
  input  logic [7:0]       brk_adrs,
  input  logic             brk_en,
  output logic             cpu_clk,
  output logic             halted,
  output logic [CYC_W-1:0] cycle_cnt
);

  localparam int DIV_W   = cnt_width(DIV_HALF);
  localparam int PULSE_W = cnt_width(PULSE_LEN);

  clk_state_t         state, state_nx;
  logic [DIV_W-1:0]   div_cnt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic               press, key_level_unused;
  logic               div_done, pulse_done, hi_nx;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clk   (clk),
    .rst   (rst),
    .key   (step_key),
    .level (key_level_unused),
    .press (press)
  );

  assign div_done   = (div_cnt == DIV_W'(DIV_HALF - 1));
  assign pulse_done = (pulse_cnt == PULSE_W'(PULSE_LEN - 1));
  assign hi_nx      = (state_nx == RUN_HI) || (state_nx == STEP_HI);

`ifdef CPU_CLK_BREAK_EN
  logic skip_brk, brk_hit;
  assign brk_hit = brk_en && (pr == brk_adrs) && !skip_brk;
`else
  logic unused_brk;
  assign unused_brk = ^{pr, brk_adrs, brk_en};
  assign halted     = 1'b0;
`endif

  // Mode changes are honoured only from low states, so high phases always run to completion.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    case (state)
      RUN_LO: if (div_done) begin
        if (step_view)    state_nx = STEP_IDLE;
`ifdef CPU_CLK_BREAK_EN
        else if (brk_hit) state_nx = BREAK;
`endif
        else              state_nx = RUN_HI;
      end
      RUN_HI:  if (div_done) state_nx = RUN_LO;
      STEP_IDLE: begin
        if (!step_view)  state_nx = RUN_LO;
        else if (press)  state_nx = STEP_HI;
      end
      STEP_HI: if (pulse_done) state_nx = STEP_IDLE;
`ifdef CPU_CLK_BREAK_EN
      BREAK: begin
        if (press)          state_nx = RUN_HI;
        else if (step_view) state_nx = STEP_IDLE;
      end
`endif
      default: state_nx = RUN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN_LO;
      div_cnt   <= '0;
      pulse_cnt <= '0;
      cpu_clk   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state   <= state_nx;
      cpu_clk <= hi_nx;
      if (state_nx != state) begin
        div_cnt   <= '0;
        pulse_cnt <= '0;
      end else begin
        if (state == RUN_LO || state == RUN_HI) div_cnt <= div_cnt + DIV_W'(1);
        if (state == STEP_HI) pulse_cnt <= pulse_cnt + PULSE_W'(1);
      end
      if (hi_nx && state_nx != state) cycle_cnt <= cycle_cnt + CYC_W'(1);
    end
  end

`ifdef CPU_CLK_BREAK_EN
  // The resume edge arms a one-shot bypass so the next run-low expiry ignores the breakpoint.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_brk <= 1'b0;
      halted   <= 1'b0;
    end else begin
      halted <= (state_nx == BREAK);
      if (state == BREAK && state_nx == RUN_HI) skip_brk <= 1'b1;
      else if (state == RUN_LO && div_done)     skip_brk <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: expected cpu_clk rises (cycle, width,
// cycle_cnt) are queued as stimulus is applied and checked as they occur.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             step_view = 1'b0;
  logic             step_key = 1'b0;
  logic [7:0]       pr = 8'h00;
  logic [7:0]       brk_adrs = 8'h05;
  logic             brk_en = 1'b0;
  logic             cpu_clk, halted;
  logic [CYC_W-1:0] cycle_cnt;

  cpu_clk_ctrl #(.DIV_HALF(4), .DEB_CYCLES(3), .PULSE_LEN(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .step_view (step_view),
    .step_key  (step_key),
    .pr        (pr),
    .brk_adrs  (brk_adrs),
    .brk_en    (brk_en),
    .cpu_clk   (cpu_clk),
    .halted    (halted),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rise_cyc;
    int width;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   rises_seen = 0;
  int   exp_cnt = 0;
  int   rise_cyc = 0;
  int   cur_w = 0;
  bit   cut_ok = 1'b0;
  logic prev_clk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_rise(input int at, input int width);
    exp_t e;
    exp_cnt++;
    e.rise_cyc = at;
    e.width    = width;
    e.cnt      = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int t = 0;
    while (rises_seen < n && t < budget) begin
      tick(1);
      t++;
    end
    check("wait_rise", rises_seen, n);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cpu_clk && !prev_clk) begin
      exp_t e;
      rises_seen++;
      rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_rise", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("rise_cyc", cyc, e.rise_cyc);
        check("rise_cnt", cycle_cnt, e.cnt);
        cur_w = e.width;
      end
    end
    if (!cpu_clk && prev_clk && !cut_ok) check("high_len", cyc - rise_cyc, cur_w);
    prev_clk = cpu_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, r;

    // Reset values
    tick(3);
    check("rst_cpu_clk", cpu_clk, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_halted", halted, 0);

    // Run mode: first rise 4 cycles after release, period 8
    r = cyc;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) push_rise(r + 4 + 8 * i, 4);
    wait_rises(5, 60);
    check("run_cnt5", cycle_cnt, 5);

    // Mode switch during RUN_HI: high phase completes, then idle low
    step_view = 1'b1;
    tick(12);
    check("mode_sw_low", cpu_clk, 0);
    check("mode_sw_rises", rises_seen, 5);

    // Clean press: rise 6 cycles after key edge, 2 cycles high
    k = cyc;
    step_key = 1'b1;
    push_rise(k + 6, 2);
    tick(10);
    step_key = 1'b0;
    wait_rises(6, 20);
    tick(10);
    check("step_cnt", cycle_cnt, 6);

    // Bounce shorter than the debounce window: no pulse
    for (int i = 0; i < 4; i++) begin
      step_key = (i % 2 == 0);
      tick(1);
    end
    step_key = 1'b0;
    tick(15);
    check("bounce_no_pulse", rises_seen, 6);

    // Clean press after bounce: exactly one pulse
    k = cyc;
    step_key = 1'b1;
    push_rise(k + 6, 2);
    tick(10);
    step_key = 1'b0;
    tick(10);
    check("post_bounce_rises", rises_seen, 7);

    // Asynchronous reset during STEP_HI
    k = cyc;
    step_key = 1'b1;
    push_rise(k + 6, 2);
    wait_rises(8, 20);
    check("pre_rst_high", cpu_clk, 1);
    cut_ok = 1'b1;
    rst = 1'b0;
    step_key = 1'b0;
    step_view = 1'b0;
    #1;
    check("async_rst_clk", cpu_clk, 0);
    check("async_rst_cnt", cycle_cnt, 0);
    tick(3);
    cut_ok = 1'b0;
    r = cyc;
    rst = 1'b1;
    exp_cnt = 0;
    push_rise(r + 4, 4);
    wait_rises(9, 20);
    step_view = 1'b1;
    tick(12);
    check("post_rst_idle", cpu_clk, 0);

    // Breakpoint at PR == brk_adrs
    k = cyc;
    brk_en = 1'b1;
    pr = 8'h05;
    step_view = 1'b0;
`ifdef CPU_CLK_BREAK_EN
    tick(10);
    for (int i = 0; i < 5; i++) begin
      check("brk_halted", halted, 1);
      check("brk_clk_low", cpu_clk, 0);
      tick(10);
    end
    k = cyc;
    step_key = 1'b1;
    push_rise(k + 6, 4);
    wait_rises(10, 20);
    step_view = 1'b1;
    step_key = 1'b0;
    check("resume_halted", halted, 0);
`else
    push_rise(k + 5, 4);
    wait_rises(10, 20);
    step_view = 1'b1;
    check("no_brk_halted", halted, 0);
`endif
    tick(12);
    check("final_cnt", cycle_cnt, 2);
    check("final_halted", halted, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
